// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, signed or
// unsigned operands, valid/ready handshake on both operand and result sides.
//
// Handshake: an operand transfer happens on a rising edge where
// in_valid && in_ready; a result transfer happens on a rising edge where
// out_valid && out_ready. in_ready depends only on state and rst, and
// out_valid only on state, so neither side sees a combinational path from the
// other side's request.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Working registers: r_quo starts as |dividend| and is shifted out MSB
  // first while quotient bits are shifted in at the bottom.
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  // Registered result, held across DONE and after the result is taken.
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_dz_out;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_div_zero;
  logic             w_ovf;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_fit;
  logic             w_last;

  assign in_ready    = (r_state == IDLE) && !rst;
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_q_out;
  assign remainder   = r_r_out;
  assign div_by_zero = r_dz_out;
  assign dbg_state   = r_state;

  assign w_accept   = in_valid && in_ready;
  assign w_a_neg    = is_signed && dividend[WIDTH-1];
  assign w_b_neg    = is_signed && divisor[WIDTH-1];
  assign w_a_abs    = w_a_neg ? -dividend : dividend;
  assign w_b_abs    = w_b_neg ? -divisor : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = is_signed && (dividend == MIN_NEG) && (divisor == '1);

  // Shift the next dividend bit into the partial remainder and try the
  // subtraction. If the shifted remainder overflowed into bit WIDTH it is
  // certainly larger than any divisor; otherwise the trial's top bit is the
  // borrow (sign) of the subtraction.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvs};
  assign w_fit    = w_rem_sh[WIDTH] || !w_trial[WIDTH];
  assign w_last   = (r_cnt == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Special cases also pass through one BUSY cycle (with a
  // zero step count) so the result register is written at a single place.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next_state = BUSY;
      BUSY: if (w_last) w_next_state = DONE;
      DONE: if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: load on accept, one restoring step per BUSY cycle, then a
  // final sign fix-up into the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_q_out  <= '0;
      r_r_out  <= '0;
      r_dz_out <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
        r_dz    <= 1'b0;
        r_dvs   <= w_b_abs;
        if (w_div_zero) begin
          r_quo <= '1;
          r_rem <= dividend;
          r_dz  <= 1'b1;
        end else if (w_ovf) begin
          r_quo <= dividend;
          r_rem <= '0;
        end else begin
          r_quo   <= w_a_abs;
          r_rem   <= '0;
          r_cnt   <= CW'(WIDTH);
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
        end
      end
    end else if (r_state == BUSY) begin
      if (!w_last) begin
        r_quo <= {r_quo[WIDTH-2:0], w_fit};
        r_rem <= w_fit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_q_out  <= r_neg_q ? -r_quo : r_quo;
        r_r_out  <= r_neg_r ? -r_rem : r_rem;
        r_dz_out <= r_dz;
      end
    end
  end

endmodule
